// File: rtl/effect_tx_pkg.sv
// effect_tx_pkg: shared types for the I2S DAC transmit path.
//   SAMPLE_W   - audio sample width
//   sample_t   - signed audio sample
//   tx_state_t - serialiser FSM states
package effect_tx_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BIT = 2'd1,
        SHIFT    = 2'd2,
        PAD      = 2'd3
    } tx_state_t;

endpackage

// File: rtl/effect_tx_fifo.sv
// effect_tx_fifo: synchronous sample FIFO between the effect chain and the
// I2S serialiser.
//   i_clk, i_rst  - clock, async active-high reset
//   i_flush       - synchronous clear of all entries
//   i_push/i_data - write request and data (accepted when not full, or when
//                   a pop happens in the same cycle)
//   i_pop/o_data  - read request and head-of-queue data (o_data valid when
//                   not empty)
//   o_fill        - occupancy, o_full / o_empty - status flags
module effect_tx_fifo
    import effect_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  sample_t                     i_data,
    input  logic                        i_pop,
    output sample_t                     o_data,
    output logic [$clog2(FIFO_DEPTH):0] o_fill,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    sample_t     mem [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign o_fill  = wr_ptr - rd_ptr;
    assign o_full  = (o_fill == (AW+1)'(FIFO_DEPTH));
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_data  = mem[rd_ptr[AW-1:0]];

    assign do_pop  = i_pop && !o_empty;
    // a pop in the same cycle frees the slot, so a push at full still fits
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/effect_i2s_dac_tx.sv
// effect_i2s_dac_tx: sink of the effect chain. Buffers valid-pulsed mono
// samples and serialises each one, I2S style, on both slots of a frame to a
// codec that is clock master (BCLK and DACLRCK are inputs).
//   i_clk, i_rst     - system clock (>= 4x BCLK), async active-high reset
//   i_valid, i_data  - one-cycle sample strobe and signed sample
//   i_enable         - 1 = transmit, 0 = mute, flush FIFO, FSM to IDLE
//   i_aud_bclk       - codec bit clock (asynchronous)
//   i_aud_daclrck    - codec LR clock (asynchronous), low = left slot
//   o_aud_dacdat     - serial data, changes on synchronised BCLK falls
//   o_fill           - FIFO occupancy
//   o_overflow       - pulse: sample dropped because the FIFO was full
//   o_underflow      - pulse: left slot started with the FIFO empty
// Build option: define I2S_TX_UNDERFLOW_HOLD_EN to repeat the last sample on
// underflow instead of sending silence.
//
// state    | meaning
// IDLE     | no frame in progress, DACDAT held low
// WAIT_BIT | LRCK edge seen, waiting out the one-BCLK I2S delay
// SHIFT    | driving the 16 sample bits MSB first
// PAD      | word done, DACDAT low until the next LRCK edge
module effect_i2s_dac_tx
    import effect_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic                        i_enable,
    input  logic [SAMPLE_W-1:0]         i_data,
    input  logic                        i_aud_bclk,
    input  logic                        i_aud_daclrck,
    output logic                        o_aud_dacdat,
    output logic [$clog2(FIFO_DEPTH):0] o_fill,
    output logic                        o_overflow,
    output logic                        o_underflow
);

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   bclk_d;
    logic                   lrck_d;
    logic                   bclk_s;
    logic                   lrck_s;
    logic                   bclk_fall;
    logic                   lrck_fall;
    logic                   lrck_edge;

    sample_t   fifo_rdata;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_pop;
    logic      underflow_evt;
    logic      overflow_evt;

    sample_t   frame_sample;
    sample_t   frame_next;
    sample_t   shift_reg;
    sample_t   shift_nxt;
    logic [3:0] bit_cnt;
    logic [3:0] cnt_nxt;
    logic      dacdat_nxt;
    logic      armed;
    logic      lrck_go;
    tx_state_t state;
    tx_state_t state_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_d    <= 1'b0;
            lrck_d    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i_aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i_aud_daclrck};
            bclk_d    <= bclk_sync[SYNC_STAGES-1];
            lrck_d    <= lrck_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync[SYNC_STAGES-1];
    assign bclk_fall = bclk_d & ~bclk_s;
    assign lrck_fall = lrck_d & ~lrck_s;
    assign lrck_edge = lrck_d ^ lrck_s;

    assign fifo_pop      = lrck_fall && i_enable && !fifo_empty;
    assign underflow_evt = lrck_fall && i_enable && fifo_empty;
    assign overflow_evt  = i_valid && i_enable && fifo_full && !fifo_pop;

    effect_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (!i_enable),
        .i_push  (i_valid && i_enable),
        .i_data  (sample_t'(i_data)),
        .i_pop   (fifo_pop),
        .o_data  (fifo_rdata),
        .o_fill  (o_fill),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // value the frame will carry; also what the shift register loads on the
    // same LRCK edge, so the popped sample is used without a cycle of delay
    always_comb begin
        frame_next = frame_sample;
        if (fifo_pop) begin
            frame_next = fifo_rdata;
        end
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
        else if (underflow_evt) begin
            frame_next = frame_sample;
        end
`else
        else if (underflow_evt) begin
            frame_next = '0;
        end
`endif
    end

    // after reset or disable only a left-slot start may begin transmission,
    // so the first word always lands in the left slot
    assign lrck_go = lrck_fall || (lrck_edge && armed);

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift_reg;
        cnt_nxt    = bit_cnt;
        dacdat_nxt = o_aud_dacdat;
        if (!i_enable) begin
            state_nxt  = IDLE;
            dacdat_nxt = 1'b0;
        end else if (lrck_go) begin
            // also covers a short slot: the unfinished word is dropped
            shift_nxt  = frame_next;
            state_nxt  = WAIT_BIT;
            dacdat_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: dacdat_nxt = 1'b0;
                WAIT_BIT: begin
                    if (bclk_fall) begin
                        dacdat_nxt = shift_reg[SAMPLE_W-1];
                        shift_nxt  = {shift_reg[SAMPLE_W-2:0], 1'b0};
                        cnt_nxt    = 4'd15;
                        state_nxt  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bclk_fall) begin
                        if (bit_cnt == 4'd0) begin
                            dacdat_nxt = 1'b0;
                            state_nxt  = PAD;
                        end else begin
                            dacdat_nxt = shift_reg[SAMPLE_W-1];
                            shift_nxt  = {shift_reg[SAMPLE_W-2:0], 1'b0};
                            cnt_nxt    = bit_cnt - 4'd1;
                        end
                    end
                end
                PAD: dacdat_nxt = 1'b0;
                default: begin
                    state_nxt  = IDLE;
                    dacdat_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            o_aud_dacdat <= 1'b0;
            frame_sample <= '0;
            armed        <= 1'b0;
            o_overflow   <= 1'b0;
            o_underflow  <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift_reg    <= shift_nxt;
            bit_cnt      <= cnt_nxt;
            o_aud_dacdat <= dacdat_nxt;
            frame_sample <= frame_next;
            o_overflow   <= overflow_evt;
            o_underflow  <= underflow_evt;
            if (!i_enable)      armed <= 1'b0;
            else if (lrck_fall) armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_effect_i2s_dac_tx.sv
module tb_effect_i2s_dac_tx;

    localparam logic [31:0] PAD_MASK = 32'hFFFE_0001;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
    localparam logic [15:0] UF_EXP = 16'h00F0;
`else
    localparam logic [15:0] UF_EXP = 16'h0000;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_enable;
    logic [15:0] i_data;
    logic        i_aud_bclk;
    logic        i_aud_daclrck;
    logic        o_aud_dacdat;
    logic [2:0]  o_fill;
    logic        o_overflow;
    logic        o_underflow;

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;
    int unf_cnt = 0;

    effect_i2s_dac_tx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_enable      (i_enable),
        .i_data        (i_data),
        .i_aud_bclk    (i_aud_bclk),
        .i_aud_daclrck (i_aud_daclrck),
        .o_aud_dacdat  (o_aud_dacdat),
        .o_fill        (o_fill),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_overflow)  ovf_cnt++;
        if (o_underflow) unf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one BCLK period = 8 i_clk; LRCK changes with the fall, data captured at the rise
    task automatic bit_cycle(input logic lr, output logic d);
        @(posedge i_clk); #2;
        i_aud_bclk = 1'b0;
        i_aud_daclrck = lr;
        repeat (4) @(posedge i_clk);
        #2;
        i_aud_bclk = 1'b1;
        d = o_aud_dacdat;
        repeat (3) @(posedge i_clk);
    endtask

    task automatic do_slot(input logic lr, input int nb, output logic [31:0] raw);
        logic d;
        raw = '0;
        for (int i = 0; i < nb; i++) begin
            bit_cycle(lr, d);
            raw[i] = d;
        end
    endtask

    function automatic logic [15:0] get_word(input logic [31:0] raw);
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[15-k] = raw[k+1];
        return w;
    endfunction

    task automatic frame(output logic [15:0] wl, output logic [15:0] wr, output logic pad_ok);
        logic [31:0] rl, rr;
        do_slot(1'b0, 32, rl);
        do_slot(1'b1, 32, rr);
        wl = get_word(rl);
        wr = get_word(rr);
        pad_ok = ((rl & PAD_MASK) == 0) && ((rr & PAD_MASK) == 0);
    endtask

    task automatic push(input logic [15:0] v);
        @(posedge i_clk); #2;
        i_valid = 1'b1;
        i_data = v;
        @(posedge i_clk); #2;
        i_valid = 1'b0;
    endtask

    logic [15:0] burst [5] = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h00F0, 16'h0BAD};
    logic [15:0] order [3] = '{16'h1234, 16'hABCD, 16'h7FFF};

    initial begin
        logic [15:0] wl, wr;
        logic        pad_ok;
        logic [31:0] rl, rr;
        logic        d;
        int          ovf0, unf0;

        i_rst = 1'b1;
        i_valid = 1'b0;
        i_enable = 1'b1;
        i_data = '0;
        i_aud_bclk = 1'b1;
        i_aud_daclrck = 1'b1;

        #23;
        check("rst_dacdat", o_aud_dacdat, 0);
        check("rst_fill", o_fill, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_underflow", o_underflow, 0);
        repeat (3) @(posedge i_clk);
        #2 i_rst = 1'b0;
        repeat (5) @(posedge i_clk);

        // basic frame
        push(16'h8001);
        check("basic_fill1", o_fill, 1);
        do_slot(1'b0, 32, rl);
        check("basic_fill0", o_fill, 0);
        do_slot(1'b1, 32, rr);
        check("basic_left", get_word(rl), 16'h8001);
        check("basic_right", get_word(rr), 16'h8001);
        check("basic_pad", ((rl & PAD_MASK) | (rr & PAD_MASK)), 0);
        check("basic_no_unf", unf_cnt, 0);

        // ordering
        for (int i = 0; i < 3; i++) push(order[i]);
        check("order_fill", o_fill, 3);
        for (int i = 0; i < 3; i++) begin
            frame(wl, wr, pad_ok);
            check($sformatf("order_left%0d", i), wl, order[i]);
            check($sformatf("order_right%0d", i), wr, order[i]);
        end
        check("order_no_unf", unf_cnt, 0);

        // overflow then underflow
        ovf0 = ovf_cnt;
        @(posedge i_clk); #2;
        i_valid = 1'b1;
        i_data = burst[0];
        for (int i = 1; i < 5; i++) begin
            @(posedge i_clk); #2;
            i_data = burst[i];
        end
        @(posedge i_clk); #2;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        check("ovf_fill", o_fill, 4);
        check("ovf_pulses", ovf_cnt - ovf0, 1);
        unf0 = unf_cnt;
        for (int i = 0; i < 4; i++) begin
            frame(wl, wr, pad_ok);
            check($sformatf("ovf_left%0d", i), wl, burst[i]);
            check($sformatf("ovf_right%0d", i), wr, burst[i]);
            check($sformatf("ovf_pad%0d", i), pad_ok, 1);
        end
        check("pre_unf_count", unf_cnt - unf0, 0);
        frame(wl, wr, pad_ok);
        check("unf_left", wl, UF_EXP);
        check("unf_right", wr, UF_EXP);
        check("unf_pulses", unf_cnt - unf0, 1);
        check("unf_fill", o_fill, 0);

        // disable mid-SHIFT
        push(16'hFFFF);
        push(16'h6666);
        push(16'h7777);
        check("dis_fill3", o_fill, 3);
        for (int i = 0; i < 6; i++) bit_cycle(1'b0, d);
        check("dis_shift_bit", d, 1);
        check("dis_fill2", o_fill, 2);
        #1 i_enable = 1'b0;
        bit_cycle(1'b0, d);
        check("dis_dacdat", d, 0);
        check("dis_fill0", o_fill, 0);
        do_slot(1'b0, 25, rl);
        do_slot(1'b1, 32, rr);
        check("dis_slot_quiet", rl | rr, 0);
        unf0 = unf_cnt;
        push(16'h4444);
        check("dis_push_ignored", o_fill, 0);
        frame(wl, wr, pad_ok);
        check("dis_frame_l", wl, 0);
        check("dis_frame_r", wr, 0);
        check("dis_no_unf", unf_cnt - unf0, 0);

        // reset mid-SHIFT
        i_enable = 1'b1;
        push(16'hFFFF);
        check("rst2_fill1", o_fill, 1);
        for (int i = 0; i < 6; i++) bit_cycle(1'b0, d);
        check("rst2_shift_bit", d, 1);
        #3 i_rst = 1'b1;
        #1;
        check("rst2_dacdat", o_aud_dacdat, 0);
        check("rst2_fill", o_fill, 0);
        check("rst2_overflow", o_overflow, 0);
        check("rst2_underflow", o_underflow, 0);
        #6 i_rst = 1'b0;
        do_slot(1'b0, 26, rl);
        do_slot(1'b1, 32, rr);
        check("rst2_quiet", rl | rr, 0);
        push(16'h1357);
        frame(wl, wr, pad_ok);
        check("rst2_left", wl, 16'h1357);
        check("rst2_right", wr, 16'h1357);
        check("rst2_pad", pad_ok, 1);

        // short slot
        push(16'hCAFE);
        push(16'h0F0F);
        do_slot(1'b0, 12, rl);
        check("short_left_top", get_word(rl) >> 5, 16'hCAFE >> 5);
        do_slot(1'b1, 32, rr);
        check("short_right", get_word(rr), 16'hCAFE);
        check("short_right_pad", rr & PAD_MASK, 0);
        frame(wl, wr, pad_ok);
        check("post_short_left", wl, 16'h0F0F);
        check("post_short_right", wr, 16'h0F0F);
        check("post_short_pad", pad_ok, 1);
        check("post_short_fill", o_fill, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
